stream_demux: RTL
=================

# stream_demux

Parametrised, registered 1-to-CH stream demultiplexer with valid/ready handshaking, the next generation of our 1-to-4 gated demux. A single input stream is steered either by an explicit select (addressed mode) or by an internal rotating pointer (auto mode). The output is a one-entry buffer per channel, so an unselected or stalled channel never sees glitching data. The block sits between a producer stream and CH independent consumer ports.

## Interface
- WIDTH, 8: data bits per word.
- CH, 4: output channel count, ≥2, need not be a power of two.
- SEL_W, $clog2(CH): select/pointer width (derived, not overridden).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = addressed (route by in_sel), 1 = auto (route by rr_ptr).
- flush  in  1  synchronous clear of all channel buffers and rr_ptr.
- in_valid  in  1  producer word valid.
- in_ready  out  1  block accepts word this cycle.
- in_data  in  WIDTH  producer word.
- in_sel  in  SEL_W  target channel in addressed mode.
- out_valid  out  CH  per-channel word valid.
- out_ready  in  CH  per-channel consumer ready.
- out_data  out  CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- rr_ptr  out  SEL_W  current auto-mode target.
- drop_cnt  out  8  saturating count of words dropped for invalid select.

## Operation
- Target channel t is in_sel when mode=0 and rr_ptr when mode=1. mode is sampled every cycle, and a change takes effect immediately. rr_ptr keeps its value across mode changes.
- Each channel holds a one-entry buffer, with state EMPTY or FULL.
  - EMPTY→FULL on accept into that channel.
  - FULL→EMPTY on out_valid&out_ready with no new accept.
  - FULL stays FULL with the new data when a drain and an accept hit the same cycle.
- in_ready = !flush & (buffer[t] EMPTY | out_ready[t]).
- Invalid select (mode=0 and in_sel ≥ CH):
  - in_ready = !flush.
  - An accepted word is discarded, and drop_cnt increments, saturating at 255.
  - No out_valid changes.
- Auto mode: on each accept, rr_ptr advances by 1 and wraps from CH-1 to 0. In addressed mode rr_ptr does not change.
- A transfer happens when in_valid & in_ready. in_data is captured into buffer[t], and out_valid[t] is set next cycle.
- out_data[k] is driven from buffer k when FULL and is 0 when EMPTY. It is never undriven (no tristates).
- flush has priority over everything:
  - all buffers go EMPTY and rr_ptr goes to 0 on the next edge.
  - drop_cnt is kept.
  - in_ready is 0 in the flush cycle, so no word is accepted.
- Reset values: out_valid=0, out_data=0, rr_ptr=0, drop_cnt=0. in_ready is forced 0 while rst_n is low and is 1 in the first cycle after release when in_valid targets any channel.

## Timing
- Latency: 1 cycle from accept edge to out_valid[t]=1 with data.
- Throughput: one word per cycle overall. Sustained on a single channel when its out_ready is held high, via same-cycle drain and refill.
- in_ready is combinational from mode, in_sel, rr_ptr, flush, buffer state and out_ready. There is no path from in_valid to in_ready.
- out_valid and out_data are registered with no combinational input paths.
- Once out_valid[k] is raised, out_data[k] stays stable until it is drained or flushed.
- Reset asserted mid-transfer clears all state immediately, asynchronously. Any word in flight is lost.

## Structure
- Shared package holds:
  - the mode encodings MODE_ADDR=0 and MODE_AUTO=1
  - DROP_W=8
  - the clog2 helper used for SEL_W
- Sub-module demux_slot is the one-entry channel buffer: load, data_in, out_ready, flush → out_valid, out_data. It is instantiated CH times in a generate loop. Top level holds the target decode, in_ready mux, rr_ptr and drop_cnt.

## Test plan
- Reset and addressed routing. Release reset, mode=0, out_ready=all 1, then send 0x11, 0x22, 0x33, 0x44 to sel 0, 1, 2, 3 on consecutive cycles. Required: each word appears on out_valid[k] exactly 1 cycle after acceptance with matching data, and every other out_data stays 0.
- Backpressure. With out_ready[2]=0, send 0xA5 then 0x5A to sel 2. Required:
  - 0xA5 is held on channel 2.
  - in_ready=0 for the second word.
  - after raising out_ready[2], 0xA5 drains and 0x5A is accepted the same cycle.
- Auto mode wrap. With mode=1 and CH=3, send 0x01..0x07. Required: channel sequence 0,1,2,0,1,2,0, and rr_ptr=1 at the end.
- Invalid select. With CH=3 and mode=0, send 300 words with in_sel=3. Required: in_ready=1 throughout, no out_valid, and drop_cnt saturates at 255.
- Flush collision. With all buffers FULL and rr_ptr=2, assert flush together with in_valid. Required:
  - in_ready=0.
  - next cycle out_valid=0, rr_ptr=0, drop_cnt unchanged.
- Async reset mid-stream. Pulse rst_n low between clock edges while channels are FULL. Required: out_valid and out_data are 0 immediately, before the next edge.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: mode encodings, counter
// width, channel-buffer state encoding and the select-width helper.
package stream_demux_pkg;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_AUTO = 1'b1
    } mode_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int DROP_W = 8;

    // Ceiling log2 with a floor of one bit, so a 2-channel build still has a select.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry channel buffer: holds a single word from load until it is drained
// or flushed; data reads as zero whenever the buffer is empty.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output slot_state_e      state
);

    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (flush) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Clearing the word on drain keeps out_data at zero while empty, straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (flush) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= data_in;
        end else if (state == SLOT_FULL && out_ready) begin
            data_q <= '0;
        end
    end

    assign out_valid = (state == SLOT_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-CH stream demultiplexer: routes each accepted word to one
// channel buffer chosen by in_sel (addressed) or by a rotating pointer (auto).
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CH    = 4,
    localparam int SEL_W = sel_width(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_W-1:0]    in_sel,
    output logic [CH-1:0]       out_valid,
    input  logic [CH-1:0]       out_ready,
    output logic [CH*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]    rr_ptr,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CH - 1);

    slot_state_e      slot_state [CH];
    logic [SEL_W-1:0] target;
    logic             auto_mode;
    logic             sel_invalid;
    logic             target_busy;
    logic             accept;
    logic [CH-1:0]    load;

    assign auto_mode   = (mode_e'(mode) == MODE_AUTO);
    assign target      = auto_mode ? rr_ptr : in_sel;
    assign sel_invalid = !auto_mode && ({1'b0, in_sel} >= CH_LIMIT);

    // A full buffer can still take a word when it drains on the same edge.
    always_comb begin
        target_busy = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (target == SEL_W'(k)) begin
                target_busy = (slot_state[k] == SLOT_FULL) && !out_ready[k];
            end
        end
    end

    // Handshake: a word moves on any edge where in_valid and in_ready are both
    // high; in_ready never looks at in_valid, and a channel word moves on
    // out_valid[k] & out_ready[k]. Invalid selects are accepted and discarded.
    assign in_ready = rst_n && !flush && (sel_invalid || !target_busy);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < CH; k++) begin
            load[k] = accept && !sel_invalid && (target == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .data_in  (in_data),
            .out_ready(out_ready[k]),
            .flush    (flush),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*WIDTH +: WIDTH]),
            .state    (slot_state[k])
        );
    end

    // The pointer only moves on auto-mode accepts and survives mode switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (accept && auto_mode) begin
            rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && sel_invalid && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
